// File: rtl/draw_scheduler_pkg.sv
// rtl/draw_scheduler_pkg.sv - shared state encoding and constants for the draw scheduler
package draw_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT     = 3'd2,
        S_NEXT     = 3'd3,
        S_INC      = 3'd4,
        S_INC_WAIT = 3'd5,
        S_FLIP     = 3'd6
    } state_t;

    localparam int LOGIC_DLY_DEF = 12;

    // Erase colour; truncated to the colour width at the point of use.
    localparam logic [31:0] BLACK = 32'd0;

endpackage

// File: rtl/draw_chan_mux.sv
// rtl/draw_chan_mux.sv - selects the active drawer's pixel stream and forces black in the erase pass
module draw_chan_mux
    import draw_scheduler_pkg::*;
#(
    parameter int NCH = 3,
    parameter int XW  = 10,
    parameter int YW  = 10,
    parameter int CW  = 3,
    parameter int AW  = 2
) (
    input  logic [AW-1:0]     sel,
    input  logic              iscolour,
    input  logic              wr_gate,
    input  logic [NCH*XW-1:0] ch_x,
    input  logic [NCH*YW-1:0] ch_y,
    input  logic [NCH*CW-1:0] ch_colour,
    input  logic [NCH-1:0]    ch_wr,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic [CW-1:0]     colour,
    output logic              wr
);

    logic [CW-1:0] sel_colour;
    logic          sel_wr;

    always_comb begin
        x          = '0;
        y          = '0;
        sel_colour = '0;
        sel_wr     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == AW'(i)) begin
                x          = ch_x[i*XW +: XW];
                y          = ch_y[i*YW +: YW];
                sel_colour = ch_colour[i*CW +: CW];
                sel_wr     = ch_wr[i];
            end
        end
        colour = iscolour ? sel_colour : BLACK[CW-1:0];
        wr     = wr_gate & sel_wr;
    end

endmodule

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - per-frame erase/logic/colour sequencer over NCH draw engines
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int NCH       = 3,
    parameter int XW        = 10,
    parameter int YW        = 10,
    parameter int CW        = 3,
    parameter int TOW       = 20,
    parameter int LOGIC_DLY = LOGIC_DLY_DEF,
    localparam int AW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [NCH-1:0]     erase_mask,
    input  logic [NCH*TOW-1:0] ch_timeout,
    input  logic [NCH-1:0]     ch_done,
    input  logic [NCH*XW-1:0]  ch_x,
    input  logic [NCH*YW-1:0]  ch_y,
    input  logic [NCH*CW-1:0]  ch_colour,
    input  logic [NCH-1:0]     ch_wr,
    output logic [NCH-1:0]     ch_go,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic [CW-1:0]      colour,
    output logic               writeEn,
    output logic               iscolour,
    output logic               inc_enable,
    output logic [AW-1:0]      active_ch,
    output logic               busy,
    output logic               overrun
);

    state_t         state_q, state_d;
    logic [AW-1:0]  active_q, active_d;
    logic           iscolour_q, iscolour_d;
    logic [TOW-1:0] cnt_q, cnt_d;
    logic           overrun_q;

    logic [NCH-1:0] pass_mask;
    logic           first_found, next_found;
    logic [AW-1:0]  first_idx, next_idx;
    logic [TOW-1:0] cur_timeout;
    logic           cur_done;
    logic [TOW-1:0] cnt_inc;
    logic           wait_exit;

    // Masking only applies to the erase pass; every channel paints in the colour pass.
    always_comb begin
        pass_mask   = iscolour_q ? '0 : erase_mask;
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!pass_mask[i]) begin
                first_found = 1'b1;
                first_idx   = AW'(i);
                if (i > int'(active_q)) begin
                    next_found = 1'b1;
                    next_idx   = AW'(i);
                end
            end
        end
    end

    always_comb begin
        cur_timeout = '0;
        cur_done    = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (active_q == AW'(i)) begin
                cur_timeout = ch_timeout[i*TOW +: TOW];
                cur_done    = ch_done[i];
            end
        end
    end

    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + TOW'(1);
    // A done pulse wins over a simultaneous timeout; both simply leave S_WAIT.
    assign wait_exit = cur_done ||
                       ((cur_timeout != '0) && (cnt_q == cur_timeout - TOW'(1)));

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        iscolour_d = iscolour_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    if (first_found) begin
                        active_d = first_idx;
                        state_d  = S_START;
                    end else begin
                        state_d  = S_INC;
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (wait_exit) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (next_found) begin
                    active_d = next_idx;
                    state_d  = S_START;
                end else begin
                    state_d  = iscolour_q ? S_FLIP : S_INC;
                end
            end
            S_INC: begin
                cnt_d   = '0;
                state_d = S_INC_WAIT;
            end
            S_INC_WAIT: begin
                cnt_d = cnt_inc;
                if (cnt_q >= TOW'(LOGIC_DLY - 1)) begin
                    state_d = S_FLIP;
                end
            end
            S_FLIP: begin
                iscolour_d = !iscolour_q;
                active_d   = '0;
                state_d    = iscolour_q ? S_IDLE : S_START;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            active_q   <= '0;
            iscolour_q <= 1'b0;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            iscolour_q <= iscolour_d;
            cnt_q      <= cnt_d;
            if (frame_tick && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Start pulses are suppressed while reset is held so a reset cannot launch a drawer.
    always_comb begin
        ch_go = '0;
        for (int i = 0; i < NCH; i++) begin
            if ((state_q == S_START) && !reset && (active_q == AW'(i))) begin
                ch_go[i] = 1'b1;
            end
        end
    end

    assign inc_enable = (state_q == S_INC) && !reset;
    assign busy       = (state_q != S_IDLE);
    assign iscolour   = iscolour_q;
    assign active_ch  = active_q;
    assign overrun    = overrun_q;

    draw_chan_mux #(
        .NCH (NCH),
        .XW  (XW),
        .YW  (YW),
        .CW  (CW),
        .AW  (AW)
    ) u_mux (
        .sel       (active_q),
        .iscolour  (iscolour_q),
        .wr_gate   (state_q == S_WAIT),
        .ch_x      (ch_x),
        .ch_y      (ch_y),
        .ch_colour (ch_colour),
        .ch_wr     (ch_wr),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .wr        (writeEn)
    );

endmodule

// File: tb/tb_draw_scheduler.sv
// tb/tb_draw_scheduler.sv - directed self-checking bench for draw_scheduler
module tb_draw_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic [2:0]  erase_mask = '0;
    logic [59:0] ch_timeout = '0;
    logic [2:0]  ch_done = '0;
    logic [29:0] ch_x = {10'd300, 10'd200, 10'd100};
    logic [29:0] ch_y = {10'd30, 10'd20, 10'd10};
    logic [8:0]  ch_colour = '0;
    logic [2:0]  ch_wr = '0;
    logic [2:0]  ch_go;
    logic [9:0]  x, y;
    logic [2:0]  colour;
    logic        writeEn, iscolour, inc_enable, busy, overrun;
    logic [1:0]  active_ch;

    int errors = 0;
    int checks = 0;

    draw_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .erase_mask (erase_mask),
        .ch_timeout (ch_timeout),
        .ch_done    (ch_done),
        .ch_x       (ch_x),
        .ch_y       (ch_y),
        .ch_colour  (ch_colour),
        .ch_wr      (ch_wr),
        .ch_go      (ch_go),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .writeEn    (writeEn),
        .iscolour   (iscolour),
        .inc_enable (inc_enable),
        .active_ch  (active_ch),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Drawer models: done pulses dly[i] cycles after go; dly 0 means never done.
    int dly[3] = '{0, 0, 0};
    int rem[3] = '{0, 0, 0};
    logic [2:0] nd;
    always @(negedge clk) begin
        nd = '0;
        for (int i = 0; i < 3; i++) begin
            if (ch_go[i]) begin
                rem[i] = dly[i];
            end else if (rem[i] > 0) begin
                rem[i] = rem[i] - 1;
                nd[i] = (rem[i] == 0);
            end
        end
        ch_done = nd;
    end

    int cyc = 0;
    int go_log[$];
    int go_cyc[$];
    int inc_cnt = 0;
    int inc_cyc = 0;
    int wen_total = 0;
    int wen_ch1 = 0;
    int wen_ch2 = 0;
    int hist[8] = '{default: 0};
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (ch_go[i]) begin
                go_log.push_back(iscolour ? 10 + i : i);
                go_cyc.push_back(cyc);
            end
        end
        if (inc_enable) begin
            inc_cnt = inc_cnt + 1;
            inc_cyc = cyc;
        end
        if (writeEn) begin
            wen_total = wen_total + 1;
            if (active_ch == 2'd1) wen_ch1 = wen_ch1 + 1;
            if (active_ch == 2'd2) wen_ch2 = wen_ch2 + 1;
            hist[colour] = hist[colour] + 1;
        end
    end

    task automatic pulse_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ch_go !== 3'b000) begin errors++; $display("FAIL reset_go got=%b exp=000", ch_go); end
        checks++; if (inc_enable !== 1'b0) begin errors++; $display("FAIL reset_inc got=%b exp=0", inc_enable); end
        checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", writeEn); end
        checks++; if (iscolour !== 1'b0) begin errors++; $display("FAIL reset_iscolour got=%b exp=0", iscolour); end
        checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL reset_active got=%0d exp=0", active_ch); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (colour !== 3'd0) begin errors++; $display("FAIL reset_colour got=%0d exp=0", colour); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int exp_log[6] = '{0, 1, 2, 10, 11, 12};
        int base, inc0, got;
        bit to;
        erase_mask = 3'b000;
        ch_timeout = '0;
        dly[0] = 30; dly[1] = 50; dly[2] = 10;
        base = go_log.size();
        inc0 = inc_cnt;
        pulse_tick();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL basic_finish got=timeout exp=idle"); end
        checks++; if (go_log.size() - base != 6) begin errors++; $display("FAIL basic_go_count got=%0d exp=6", go_log.size() - base); end
        for (int k = 0; k < 6; k++) begin
            got = (base + k < go_log.size()) ? go_log[base + k] : -1;
            checks++; if (got != exp_log[k]) begin errors++; $display("FAIL basic_go_order[%0d] got=%0d exp=%0d", k, got, exp_log[k]); end
        end
        checks++; if (inc_cnt - inc0 != 1) begin errors++; $display("FAIL basic_inc_count got=%0d exp=1", inc_cnt - inc0); end
        got = (base + 3 < go_cyc.size()) ? go_cyc[base + 3] - inc_cyc : -1;
        checks++; if (got != 14) begin errors++; $display("FAIL basic_inc_to_colour_go got=%0d exp=14", got); end
        checks++; if (iscolour !== 1'b0) begin errors++; $display("FAIL basic_iscolour_end got=%b exp=0", iscolour); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_mask();
        int exp_log[5] = '{0, 2, 10, 11, 12};
        int base, got;
        bit to;
        erase_mask = 3'b010;
        dly[0] = 5; dly[1] = 5; dly[2] = 5;
        base = go_log.size();
        pulse_tick();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL mask_finish got=timeout exp=idle"); end
        checks++; if (go_log.size() - base != 5) begin errors++; $display("FAIL mask_go_count got=%0d exp=5", go_log.size() - base); end
        for (int k = 0; k < 5; k++) begin
            got = (base + k < go_log.size()) ? go_log[base + k] : -1;
            checks++; if (got != exp_log[k]) begin errors++; $display("FAIL mask_go_order[%0d] got=%0d exp=%0d", k, got, exp_log[k]); end
        end
        erase_mask = 3'b000;
    endtask

    task automatic test_timeout();
        int base, w2;
        bit to;
        dly[0] = 5; dly[1] = 5; dly[2] = 0;
        ch_timeout = {20'd20, 20'd0, 20'd0};
        ch_wr = 3'b100;
        base = go_log.size();
        w2 = wen_ch2;
        pulse_tick();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL timeout_finish got=timeout exp=idle"); end
        checks++; if (go_log.size() - base != 6) begin errors++; $display("FAIL timeout_go_count got=%0d exp=6", go_log.size() - base); end
        checks++; if (wen_ch2 - w2 != 40) begin errors++; $display("FAIL timeout_wait_cycles got=%0d exp=40", wen_ch2 - w2); end
        ch_timeout = '0;
        ch_wr = 3'b000;
    endtask

    task automatic test_colour();
        int h0[8];
        int wt, w1;
        bit to;
        dly[0] = 4; dly[1] = 4; dly[2] = 4;
        ch_wr = 3'b111;
        ch_colour = {3'b111, 3'b111, 3'b111};
        h0 = hist;
        pulse_tick();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL colour_a_finish got=timeout exp=idle"); end
        checks++; if (hist[0] - h0[0] != 12) begin errors++; $display("FAIL colour_erase_black got=%0d exp=12", hist[0] - h0[0]); end
        checks++; if (hist[7] - h0[7] != 12) begin errors++; $display("FAIL colour_pass_white got=%0d exp=12", hist[7] - h0[7]); end
        ch_wr = 3'b010;
        ch_colour = {3'b011, 3'b101, 3'b110};
        h0 = hist;
        wt = wen_total;
        w1 = wen_ch1;
        pulse_tick();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL colour_b_finish got=timeout exp=idle"); end
        checks++; if (wen_total - wt != 8) begin errors++; $display("FAIL colour_wen_total got=%0d exp=8", wen_total - wt); end
        checks++; if (wen_ch1 - w1 != 8) begin errors++; $display("FAIL colour_wen_ch1 got=%0d exp=8", wen_ch1 - w1); end
        checks++; if (hist[0] - h0[0] != 4) begin errors++; $display("FAIL colour_b_black got=%0d exp=4", hist[0] - h0[0]); end
        checks++; if (hist[5] - h0[5] != 4) begin errors++; $display("FAIL colour_b_ch1 got=%0d exp=4", hist[5] - h0[5]); end
        ch_wr = 3'b000;
    endtask

    task automatic test_overrun();
        int base;
        bit to;
        dly[0] = 30; dly[1] = 50; dly[2] = 10;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_before got=%b exp=0", overrun); end
        base = go_log.size();
        pulse_tick();
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        #1;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", overrun); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL overrun_finish got=timeout exp=idle"); end
        repeat (20) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overrun_no_second_frame got=%b exp=0", busy); end
        checks++; if (go_log.size() - base != 6) begin errors++; $display("FAIL overrun_go_count got=%0d exp=6", go_log.size() - base); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_reset_mid();
        int base, inc0;
        dly[0] = 30; dly[1] = 30; dly[2] = 30;
        ch_wr = 3'b111;
        ch_colour = {3'b111, 3'b111, 3'b111};
        pulse_tick();
        repeat (8) @(negedge clk);
        #1;
        checks++; if (writeEn !== 1'b1) begin errors++; $display("FAIL mid_in_wait got=%b exp=1", writeEn); end
        @(negedge clk);
        reset = 1'b1;
        base = go_log.size();
        inc0 = inc_cnt;
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL mid_wen got=%b exp=0", writeEn); end
        checks++; if (ch_go !== 3'b000) begin errors++; $display("FAIL mid_go got=%b exp=000", ch_go); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun got=%b exp=0", overrun); end
        checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL mid_active got=%0d exp=0", active_ch); end
        checks++; if (colour !== 3'd0) begin errors++; $display("FAIL mid_colour got=%0d exp=0", colour); end
        checks++; if (x !== 10'd100) begin errors++; $display("FAIL mid_x_passthrough got=%0d exp=100", x); end
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_late_done_busy got=%b exp=0", busy); end
        checks++; if (go_log.size() != base) begin errors++; $display("FAIL mid_no_go got=%0d exp=0", go_log.size() - base); end
        checks++; if (inc_cnt != inc0) begin errors++; $display("FAIL mid_no_inc got=%0d exp=0", inc_cnt - inc0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_timeout();
        test_colour();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
